exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 16, 32, 64.
REQ-002 Parameter NUM_FWD, default 2, number of forwarding sources (slot 0 = MEM result, slot 1 = WB result, further slots are later stages).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid_in  in  1  EXE holds a valid instruction this cycle.
REQ-006 flush_exe  in  1  cancel the instruction in EXE, including any in-flight multi-cycle op.
REQ-007 rdata1_exe, rdata2_exe  in  XLEN each  register-file operands.
REQ-008 fwd_data  in  NUM_FWD*XLEN  forwarding values; slot k occupies bits [k*XLEN +: XLEN].
REQ-009 forward_rd1_exe, forward_rd2_exe  in  FW=$clog2(NUM_FWD+1) each  forwarding selects: 0 = register operand, k = fwd_data slot k-1; values above NUM_FWD select the register operand.
REQ-010 pc_exe, Imm_exe  in  XLEN each  PC and immediate.
REQ-011 selA, selB  in  1 each  ALU input muxes: selA=1 selects pc_exe, selB=1 selects Imm_exe.
REQ-012 ALUCtrl  in  4  ALU operation, encoded exactly as in the existing ALU module.
REQ-013 BrUn_exe  in  1  branch compare is unsigned.
REQ-014 md_en  in  1  instruction is an M-extension op; md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-015 alu_result_ex  out  XLEN  execute result; rdata2_forwarded  out  XLEN  forwarded rs2 value for stores.
REQ-016 BrEq_exe, BrLt_exe  out  1 each  branch comparator outputs on the forwarded rs1/rs2.
REQ-017 stall_exe  out  1  freeze IF/ID/EXE; result_valid  out  1  alu_result_ex is final this cycle.

Function
REQ-018 Forwarding, the ALU input muxes, the ALU and the branch comparator shall be combinational with zero latency; result_valid=valid_in & ~md_en in state IDLE.
REQ-019 The FSM shall have states IDLE, BUSY and DONE, plus a cycle counter of $clog2(XLEN)+1 bits.
REQ-020 IDLE, valid_in & md_en & ~flush_exe: stall_exe=1 combinationally; the forwarded operands and md_op shall be latched; next state BUSY with count 0, or DONE for a special case (REQ-025, REQ-026).
REQ-021 BUSY: stall_exe=1; one radix-2 step per cycle (shift-add multiply or restoring divide) on operand magnitudes; after XLEN steps go to DONE.
REQ-022 DONE: stall_exe=0, result_valid=1, alu_result_ex=muldiv result; next state IDLE unconditionally, so the held instruction is not reissued.
REQ-023 Latency: a normal M op stalls for exactly XLEN+1 cycles (the issue cycle plus XLEN BUSY cycles) and delivers its result in the following DONE cycle.
REQ-024 Sign and width rules:
- MUL returns the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits.
- Signed operands are converted to magnitude at issue and the result is negated at DONE when the signs differ; the remainder takes the sign of the dividend.
REQ-025 Divide by zero: go directly to DONE; quotient = all ones, remainder = dividend; stall_exe=1 for one cycle.
REQ-026 Signed overflow (DIV/REM of -2^(XLEN-1) by -1): go directly to DONE; quotient = -2^(XLEN-1), remainder = 0.
REQ-027 Operand changes on the inputs after issue shall not affect an in-flight op.
REQ-028 flush_exe in BUSY or DONE: next state IDLE and stall_exe=0 that same cycle; no result is produced (result_valid=0).
REQ-029 flush_exe and issue in the same cycle: flush wins and the FSM stays in IDLE.
REQ-030 valid_in=0 or md_en=0 in IDLE: the FSM stays in IDLE.

Reset
REQ-031 While reset=1, on the next clock edge: state=IDLE, counter and latched operands=0, result register=0.
REQ-032 After reset: stall_exe=0 and result_valid=0 until valid_in=1.
REQ-033 Reset mid-operation shall abandon the op; the cycle after reset is sampled shall show stall_exe=0.

Verification (XLEN=32, NUM_FWD=2)
REQ-034 Forwarding + ALU: rdata1=5, fwd slot0=10, forward_rd2_exe=1, ALUCtrl=ADD, selA=selB=0 -> alu_result_ex=15, rdata2_forwarded=10, result_valid=1 in the same cycle.
REQ-035 MUL: 7 * 0xFFFFFFFD -> stall_exe high for 33 cycles, then DONE with alu_result_ex=0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 Divide by zero: DIV 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; stall_exe high for 1 cycle.
REQ-037 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-038 Flush/reset: flush_exe in BUSY cycle 10 -> stall_exe=0 immediately and no result_valid; reset in BUSY cycle 10 -> IDLE and stall_exe=0 the next cycle.
REQ-039 Back-to-back: DIVU 100/7 followed by REMU 100/7 -> results 14 then 2, with no reissue of the first op in DONE.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv: execute stage with operand forwarding, ALU, branch comparator and an
// iterative RV32M/RV64M multiply/divide unit (one radix-2 step per cycle).
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   valid_in, flush_exe               instruction valid / cancel instruction in EXE
//   rdata1_exe, rdata2_exe            register-file operands
//   fwd_data                          NUM_FWD forwarding values, slot k at [k*XLEN +: XLEN]
//   forward_rd1_exe, forward_rd2_exe  0 = register operand, k = slot k-1, >NUM_FWD = register
//   pc_exe, Imm_exe, selA, selB       ALU input muxes (selA -> pc, selB -> immediate)
//   ALUCtrl, BrUn_exe                 ALU operation, unsigned branch compare
//   md_en, md_op                      M-extension op enable and funct3
//   alu_result_ex, rdata2_forwarded   execute result, forwarded rs2 for stores
//   BrEq_exe, BrLt_exe                branch comparator outputs
//   stall_exe, result_valid           pipeline freeze, result is final this cycle
module exe_muldiv #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    localparam int unsigned FW     = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic                    flush_exe,
    input  logic [XLEN-1:0]         rdata1_exe,
    input  logic [XLEN-1:0]         rdata2_exe,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [FW-1:0]           forward_rd1_exe,
    input  logic [FW-1:0]           forward_rd2_exe,
    input  logic [XLEN-1:0]         pc_exe,
    input  logic [XLEN-1:0]         Imm_exe,
    input  logic                    selA,
    input  logic                    selB,
    input  logic [3:0]              ALUCtrl,
    input  logic                    BrUn_exe,
    input  logic                    md_en,
    input  logic [2:0]              md_op,
    output logic [XLEN-1:0]         alu_result_ex,
    output logic [XLEN-1:0]         rdata2_forwarded,
    output logic                    BrEq_exe,
    output logic                    BrLt_exe,
    output logic                    stall_exe,
    output logic                    result_valid
);

    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    // ALU operation encoding: {funct7[5], funct3} style, plus pass-B for LUI.
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSll  = 4'd1;
    localparam logic [3:0] AluSlt  = 4'd2;
    localparam logic [3:0] AluSltu = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSrl  = 4'd5;
    localparam logic [3:0] AluOr   = 4'd6;
    localparam logic [3:0] AluAnd  = 4'd7;
    localparam logic [3:0] AluSub  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd13;
    localparam logic [3:0] AluPassB = 4'd15;

    // ------------------------------------------------------------------
    // Forwarding, ALU input muxes, ALU, branch comparator
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] fwd_pick(input logic [FW-1:0]           sel,
                                                 input logic [XLEN-1:0]         reg_val,
                                                 input logic [NUM_FWD*XLEN-1:0] fwd);
        logic [XLEN-1:0] v;
        v = reg_val;
        for (int k = 1; k <= int'(NUM_FWD); k++) begin
            if (int'(sel) == k) v = fwd[(k-1)*XLEN +: XLEN];
        end
        return v;
    endfunction

    logic [XLEN-1:0] opa, opb, alu_a, alu_b, alu_out;
    logic [SW-1:0]   shamt;

    assign opa              = fwd_pick(forward_rd1_exe, rdata1_exe, fwd_data);
    assign opb              = fwd_pick(forward_rd2_exe, rdata2_exe, fwd_data);
    assign rdata2_forwarded = opb;
    assign alu_a            = selA ? pc_exe : opa;
    assign alu_b            = selB ? Imm_exe : opb;
    assign shamt            = alu_b[SW-1:0];

    always_comb begin
        alu_out = '0;
        case (ALUCtrl)
            AluAdd:   alu_out = alu_a + alu_b;
            AluSub:   alu_out = alu_a - alu_b;
            AluSll:   alu_out = alu_a << shamt;
            AluSrl:   alu_out = alu_a >> shamt;
            AluSra:   alu_out = $unsigned($signed(alu_a) >>> shamt);
            AluSlt:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            AluSltu:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            AluXor:   alu_out = alu_a ^ alu_b;
            AluOr:    alu_out = alu_a | alu_b;
            AluAnd:   alu_out = alu_a & alu_b;
            AluPassB: alu_out = alu_b;
            default:  alu_out = '0;
        endcase
    end

    assign BrEq_exe = (opa == opb);
    assign BrLt_exe = BrUn_exe ? (opa < opb) : ($signed(opa) < $signed(opb));

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    // hi/lo: product {hi,lo} for multiply, {remainder, quotient} for divide.
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            neg_q, neg_d;    // negate product / quotient
    logic            rneg_q, rneg_d;  // negate remainder
    logic            raw_q, raw_d;    // special case: hi/lo already hold the final result

    logic            issue, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign issue    = valid_in & md_en & ~flush_exe;
    assign a_signed = md_op[2] ? ~md_op[0] : (md_op[1:0] != 2'd3);
    assign b_signed = md_op[2] ? ~md_op[0] : ~md_op[1];
    assign a_neg    = a_signed & opa[XLEN-1];
    assign b_neg    = b_signed & opb[XLEN-1];
    assign a_mag    = a_neg ? (~opa + 1'b1) : opa;
    assign b_mag    = b_neg ? (~opb + 1'b1) : opb;
    assign div_zero = md_op[2] & (opb == '0);
    assign div_ovf  = md_op[2] & ~md_op[0] & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (opb == '1);

    // One step of each algorithm from the current registers.
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_trial;
    logic            div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    // The trial remainder is below the divisor when kept, so modulo-XLEN arithmetic suffices.
    assign div_trial = div_shift[XLEN-1:0] - b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        raw_d   = raw_q;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    op_d   = md_op;
                    b_d    = b_mag;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    if (div_zero) begin
                        hi_d    = opa;
                        lo_d    = '1;
                        raw_d   = 1'b1;
                        state_d = StDone;
                    end else if (div_ovf) begin
                        hi_d    = '0;
                        lo_d    = opa;
                        raw_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        hi_d    = '0;
                        lo_d    = a_mag;
                        raw_d   = 1'b0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush_exe) begin
                    state_d = StIdle;
                end else begin
                    if (!op_q[2]) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_d = div_ge ? div_trial : div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) state_d = StDone;
                end
            end
            // Always return to IDLE so the held instruction is not reissued.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            raw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            raw_q   <= raw_d;
        end
    end

    // Sign fix-up of the magnitude result.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, md_result;

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? (~prod + 1'b1) : prod;
    assign quo_s  = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign rem_s  = rneg_q ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        md_result = '0;
        if (!op_q[2]) begin
            md_result = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (raw_q) begin
            md_result = op_q[1] ? hi_q : lo_q;
        end else begin
            md_result = op_q[1] ? rem_s : quo_s;
        end
    end

    always_comb begin
        stall_exe     = 1'b0;
        result_valid  = 1'b0;
        alu_result_ex = alu_out;
        case (state_q)
            StIdle: begin
                stall_exe    = issue;
                result_valid = valid_in & ~md_en;
            end
            StBusy: stall_exe = ~flush_exe;
            StDone: begin
                result_valid  = ~flush_exe;
                alu_result_ex = md_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// Testbench for exe_muldiv (XLEN=32, NUM_FWD=2): vector table for forwarding/ALU/branch,
// directed multi-cycle sequences, and random traffic against a behavioural model.
module tb_exe_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, flush_exe;
    logic [31:0] rdata1_exe, rdata2_exe, pc_exe, Imm_exe;
    logic [63:0] fwd_data;
    logic [1:0]  forward_rd1_exe, forward_rd2_exe;
    logic        selA, selB, BrUn_exe, md_en;
    logic [3:0]  ALUCtrl;
    logic [2:0]  md_op;
    logic [31:0] alu_result_ex, rdata2_forwarded;
    logic        BrEq_exe, BrLt_exe, stall_exe, result_valid;

    int total = 0;
    int bad   = 0;

    exe_muldiv #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .flush_exe        (flush_exe),
        .rdata1_exe       (rdata1_exe),
        .rdata2_exe       (rdata2_exe),
        .fwd_data         (fwd_data),
        .forward_rd1_exe  (forward_rd1_exe),
        .forward_rd2_exe  (forward_rd2_exe),
        .pc_exe           (pc_exe),
        .Imm_exe          (Imm_exe),
        .selA             (selA),
        .selB             (selB),
        .ALUCtrl          (ALUCtrl),
        .BrUn_exe         (BrUn_exe),
        .md_en            (md_en),
        .md_op            (md_op),
        .alu_result_ex    (alu_result_ex),
        .rdata2_forwarded (rdata2_forwarded),
        .BrEq_exe         (BrEq_exe),
        .BrLt_exe         (BrLt_exe),
        .stall_exe        (stall_exe),
        .result_valid     (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [63:0] f);
        if (sel == 2'd1) return f[31:0];
        if (sel == 2'd2) return f[63:32];
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd1:    return a << sh;
            4'd5:    return a >> sh;
            4'd13:   return $unsigned($signed(a) >>> sh);
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd15:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                r = sa / sb; p = r; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = sa % sb; p = r; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_stall(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op >= 3'd4 && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        valid_in = 1'b0; flush_exe = 1'b0; md_en = 1'b0; md_op = 3'd0;
        rdata1_exe = '0; rdata2_exe = '0; fwd_data = '0; pc_exe = '0; Imm_exe = '0;
        forward_rd1_exe = 2'd0; forward_rd2_exe = 2'd0; selA = 1'b0; selB = 1'b0;
        ALUCtrl = 4'd0; BrUn_exe = 1'b0;
    endtask

    // Issue an M op from the current cycle, scramble inputs while it runs, check
    // stall length and final result, then leave one clock later with inputs released.
    task automatic run_md(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [63:0] f,
                          input logic [31:0] exp, input int exp_stall, input string nm);
        int n;
        valid_in = 1'b1; md_en = 1'b1; md_op = op; flush_exe = 1'b0;
        forward_rd1_exe = s1; forward_rd2_exe = s2;
        rdata1_exe = r1; rdata2_exe = r2; fwd_data = f;
        #1;
        n = 0;
        while (stall_exe && n < 200) begin
            n++;
            @(posedge clk);
            #1;
            rdata1_exe = $urandom; rdata2_exe = $urandom; fwd_data = {$urandom, $urandom};
            #1;
        end
        chk({nm, "_stall"}, 64'(n), 64'(exp_stall));
        chk({nm, "_rv"}, {63'd0, result_valid}, 64'd1);
        chk({nm, "_res"}, {32'd0, alu_result_ex}, {32'd0, exp});
        @(posedge clk);
        #1;
        valid_in = 1'b0; md_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] rd1, rd2, f0, f1, pc, imm;
        logic [1:0]  s1, s2;
        logic        sa, sb;
        logic [3:0]  ctrl;
        logic        brun;
        logic [31:0] e_res, e_rd2;
        logic        e_eq, e_lt;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [3:0]  ctrls [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                    4'd13, 4'd15};
        int rv_cnt;

        vt[0] = '{32'd5, 32'd0, 32'd10, 32'd0, 32'd0, 32'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'd0,
                  1'b0, 32'd15, 32'd10, 1'b0, 1'b1};
        vt[1] = '{32'd3, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd8,
                  1'b0, 32'hFFFF_FFFB, 32'd8, 1'b0, 1'b1};
        vt[2] = '{32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'd2, 2'd0, 1'b0, 1'b0,
                  4'd3, 1'b1, 32'd0, 32'd1, 1'b0, 1'b0};
        vt[3] = '{32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'd2, 2'd0, 1'b0, 1'b0,
                  4'd2, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1};
        vt[4] = '{32'h12, 32'h12, 32'hAA, 32'hBB, 32'd0, 32'd0, 2'd3, 2'd3, 1'b0, 1'b0,
                  4'd7, 1'b0, 32'h12, 32'h12, 1'b1, 1'b0};
        vt[5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'h1000, 32'h24, 2'd0, 2'd0, 1'b1, 1'b1,
                  4'd0, 1'b0, 32'h1024, 32'd7, 1'b1, 1'b0};
        vt[6] = '{32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0,
                  4'd13, 1'b0, 32'hF800_0000, 32'd4, 1'b0, 1'b1};
        vt[7] = '{32'hF0F0_F0F0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_0000, 2'd0, 2'd0,
                  1'b0, 1'b1, 4'd4, 1'b1, 32'h0F0F_F0F0, 32'd0, 1'b0, 1'b0};

        // Reset
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_stall", {63'd0, stall_exe}, 64'd0);
        chk("reset_rv", {63'd0, result_valid}, 64'd0);
        chk("reset_alu", {32'd0, alu_result_ex}, 64'd0);

        // Vector table: forwarding, ALU muxes, ALU, comparator
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; md_en = 1'b0;
            rdata1_exe = vt[i].rd1; rdata2_exe = vt[i].rd2; fwd_data = {vt[i].f1, vt[i].f0};
            pc_exe = vt[i].pc; Imm_exe = vt[i].imm;
            forward_rd1_exe = vt[i].s1; forward_rd2_exe = vt[i].s2;
            selA = vt[i].sa; selB = vt[i].sb; ALUCtrl = vt[i].ctrl; BrUn_exe = vt[i].brun;
            #1;
            chk($sformatf("vec%0d_res", i), {32'd0, alu_result_ex}, {32'd0, vt[i].e_res});
            chk($sformatf("vec%0d_rd2", i), {32'd0, rdata2_forwarded}, {32'd0, vt[i].e_rd2});
            chk($sformatf("vec%0d_eq", i), {63'd0, BrEq_exe}, {63'd0, vt[i].e_eq});
            chk($sformatf("vec%0d_lt", i), {63'd0, BrLt_exe}, {63'd0, vt[i].e_lt});
            chk($sformatf("vec%0d_rv", i), {62'd0, result_valid, stall_exe}, 64'd2);
            tick();
        end

        // Random ALU traffic
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            valid_in = 1'b1; md_en = 1'b0;
            rdata1_exe = $urandom; rdata2_exe = $urandom; fwd_data = {$urandom, $urandom};
            pc_exe = $urandom; Imm_exe = $urandom;
            forward_rd1_exe = 2'($urandom_range(0, 3)); forward_rd2_exe = 2'($urandom_range(0, 3));
            selA = 1'($urandom); selB = 1'($urandom); BrUn_exe = 1'($urandom);
            ALUCtrl = ctrls[$urandom_range(0, 10)];
            if ($urandom_range(0, 7) == 0) rdata2_exe = rdata1_exe;
            a = ref_fwd(forward_rd1_exe, rdata1_exe, fwd_data);
            b = ref_fwd(forward_rd2_exe, rdata2_exe, fwd_data);
            #1;
            chk("rnd_alu", {32'd0, alu_result_ex},
                {32'd0, ref_alu(ALUCtrl, selA ? pc_exe : a, selB ? Imm_exe : b)});
            chk("rnd_rd2", {32'd0, rdata2_forwarded}, {32'd0, b});
            chk("rnd_br", {62'd0, BrEq_exe, BrLt_exe},
                {62'd0, a == b, BrUn_exe ? (a < b) : ($signed(a) < $signed(b))});
            tick();
        end
        idle_inputs();
        tick();

        // Directed M-extension cases
        run_md(3'd0, 2'd0, 2'd0, 32'd7, 32'hFFFF_FFFD, 64'd0, 32'hFFFF_FFEB, 33, "mul");
        run_md(3'd3, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 32'hFFFF_FFFE, 33, "mulhu");
        run_md(3'd1, 2'd0, 2'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 32'h4000_0000, 33, "mulh");
        run_md(3'd2, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd2, 64'd0, 32'hFFFF_FFFF, 33, "mulhsu");
        run_md(3'd4, 2'd0, 2'd0, 32'd100, 32'd0, 64'd0, 32'hFFFF_FFFF, 1, "div0");
        run_md(3'd6, 2'd0, 2'd0, 32'd100, 32'd0, 64'd0, 32'd100, 1, "rem0");
        run_md(3'd4, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 32'h8000_0000, 1, "divovf");
        run_md(3'd6, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 32'd0, 1, "removf");
        run_md(3'd4, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, 64'd0, 32'hFFFF_FFFD, 33, "divneg");
        run_md(3'd6, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, 64'd0, 32'hFFFF_FFFF, 33, "remneg");
        // Operands via forwarding slots
        run_md(3'd5, 2'd1, 2'd2, 32'd0, 32'd0, {32'd6, 32'd45}, 32'd7, 33, "divu_fwd");
        // Back-to-back: second op issues right after DONE
        run_md(3'd5, 2'd0, 2'd0, 32'd100, 32'd7, 64'd0, 32'd14, 33, "b2b_divu");
        run_md(3'd7, 2'd0, 2'd0, 32'd100, 32'd7, 64'd0, 32'd2, 33, "b2b_remu");
        tick();
        chk("post_b2b_idle", {62'd0, stall_exe, result_valid}, 64'd0);

        // Flush and issue in the same cycle: flush wins
        valid_in = 1'b1; md_en = 1'b1; md_op = 3'd0; flush_exe = 1'b1;
        #1;
        chk("flush_issue_stall", {63'd0, stall_exe}, 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("flush_issue_idle", {62'd0, stall_exe, result_valid}, 64'd0);

        // Flush in BUSY cycle 10
        valid_in = 1'b1; md_en = 1'b1; md_op = 3'd0; rdata1_exe = 32'd3; rdata2_exe = 32'd5;
        #1;
        chk("flush_issue", {63'd0, stall_exe}, 64'd1);
        repeat (10) tick();
        chk("flush_busy", {63'd0, stall_exe}, 64'd1);
        flush_exe = 1'b1; valid_in = 1'b0; md_en = 1'b0;
        #1;
        chk("flush_now", {62'd0, stall_exe, result_valid}, 64'd0);
        tick();
        flush_exe = 1'b0;
        #1;
        rv_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid || stall_exe) rv_cnt++;
            tick();
        end
        chk("flush_no_result", 64'(rv_cnt), 64'd0);

        // Reset in BUSY cycle 10
        valid_in = 1'b1; md_en = 1'b1; md_op = 3'd5; rdata1_exe = 32'd99; rdata2_exe = 32'd4;
        #1;
        repeat (10) tick();
        chk("rst_busy", {63'd0, stall_exe}, 64'd1);
        reset = 1'b1; valid_in = 1'b0; md_en = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_after", {62'd0, stall_exe, result_valid}, 64'd0);
        rv_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid || stall_exe) rv_cnt++;
            tick();
        end
        chk("rst_no_result", 64'(rv_cnt), 64'd0);

        // Random M-extension traffic
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  op;
            logic [1:0]  s1, s2;
            logic [31:0] r1, r2, a, b;
            logic [63:0] f;
            int          kind;
            op = 3'($urandom_range(0, 7));
            s1 = 2'($urandom_range(0, 3)); s2 = 2'($urandom_range(0, 3));
            r1 = $urandom; r2 = $urandom; f = {$urandom, $urandom};
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                s2 = 2'd0; r2 = 32'd0;
            end else if (kind == 1) begin
                s1 = 2'd0; s2 = 2'd0; r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF;
            end else if (kind == 2) begin
                s2 = 2'd0; r2 = 32'($urandom_range(1, 300));
            end
            a = ref_fwd(s1, r1, f);
            b = ref_fwd(s2, r2, f);
            run_md(op, s1, s2, r1, r2, f, ref_md(op, a, b), ref_stall(op, a, b),
                   $sformatf("rnd_md%0d_op%0d", i, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
